// File: rtl/pong_motion_ctrl_if.sv
// Key/serve controls into the motion engine and sprite positions out to the VGA address generators.
interface pong_motion_ctrl_if;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned SCORE_W = 8;

  logic               frame_tick;
  logic               key_left;
  logic               key_right;
  logic               launch;
  logic [POS_W-1:0]   paddle_x;
  logic [POS_W-1:0]   ball_x;
  logic [POS_W-1:0]   ball_y;
  logic               ball_live;
  logic               miss;
  logic [SCORE_W-1:0] score;

  modport master (
    output frame_tick, key_left, key_right, launch,
    input  paddle_x, ball_x, ball_y, ball_live, miss, score
  );

  modport slave (
    input  frame_tick, key_left, key_right, launch,
    output paddle_x, ball_x, ball_y, ball_live, miss, score
  );
endinterface

// File: rtl/pong_motion_ctrl.sv
// Frame-rate paddle/ball motion engine with serve/play/miss FSM and saturating hit score.
// Optional macro AUTO_SERVE_EN: IDLE also serves by itself after 60 frame ticks without launch.
module pong_motion_ctrl #(
  parameter int unsigned SCR_W       = 320,
  parameter int unsigned SCR_H       = 240,
  parameter int unsigned PAD_W       = 32,
  parameter int unsigned PAD_Y       = 190,
  parameter int unsigned BALL_SZ     = 16,
  parameter int unsigned PAD_STEP    = 8,
  parameter int unsigned BALL_SPD    = 1,
  parameter int unsigned MISS_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  pong_motion_ctrl_if.slave bus
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned CNT_W   = 8;

  localparam logic [POS_W-1:0] PAD_MAX  = POS_W'(SCR_W - PAD_W);
  localparam logic [POS_W-1:0] PAD_RST  = POS_W'((SCR_W - PAD_W) / 2);
  localparam logic [POS_W-1:0] BALL_OFS = POS_W'((PAD_W - BALL_SZ) / 2);
  localparam logic [POS_W-1:0] REST_Y   = POS_W'(PAD_Y - BALL_SZ);
  localparam logic [POS_W-1:0] BX_MAX   = POS_W'(SCR_W - BALL_SZ);
  localparam logic [POS_W-1:0] BY_MAX   = POS_W'(SCR_H - BALL_SZ);
  localparam logic [POS_W-1:0] STEP     = POS_W'(PAD_STEP);
  localparam logic [POS_W-1:0] SPD      = POS_W'(BALL_SPD);
  localparam logic [POS_W-1:0] SZ       = POS_W'(BALL_SZ);
  localparam logic [POS_W-1:0] PW       = POS_W'(PAD_W);
  localparam logic [POS_W-1:0] PY       = POS_W'(PAD_Y);
  localparam logic [POS_W-1:0] SH       = POS_W'(SCR_H);
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);
`ifdef AUTO_SERVE_EN
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(59);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MISS = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   paddle_q, paddle_d;
  logic [POS_W-1:0]   ball_x_q, ball_x_d;
  logic [POS_W-1:0]   ball_y_q, ball_y_d;
  logic               vx_q, vx_d;   // 1 = moving right
  logic               vy_q, vy_d;   // 1 = moving down
  logic [SCORE_W-1:0] score_q, score_d;
  logic               live_q, live_d;
  logic               miss_q, miss_d;
  logic               launch_pend_q, launch_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               launch_now_c;
  logic               pad_hit_c;

  // Serve request seen this tick, whether latched earlier or arriving with the tick itself.
  assign launch_now_c = launch_pend_q | bus.launch;

  // Descending ball lands on the paddle this frame (pre-update positions).
  assign pad_hit_c = (ball_y_q + SZ <= PY) && (ball_y_q + SZ + SPD >= PY) &&
                     (ball_x_q + SZ > paddle_q) && (ball_x_q < paddle_q + PW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      paddle_q      <= PAD_RST;
      ball_x_q      <= PAD_RST + BALL_OFS;
      ball_y_q      <= REST_Y;
      vx_q          <= 1'b1;
      vy_q          <= 1'b0;
      score_q       <= '0;
      live_q        <= 1'b0;
      miss_q        <= 1'b0;
      launch_pend_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddle_q      <= paddle_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      score_q       <= score_d;
      live_q        <= live_d;
      miss_q        <= miss_d;
      launch_pend_q <= launch_pend_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddle_d      = paddle_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    score_d       = score_q;
    miss_d        = 1'b0;
    cnt_d         = cnt_q;
    launch_pend_d = launch_pend_q | bus.launch;

    if (bus.frame_tick) begin
      launch_pend_d = 1'b0;

      // Clamp checks come before the add/subtract so positions never wrap.
      if (bus.key_right && !bus.key_left) begin
        paddle_d = (paddle_q + STEP >= PAD_MAX) ? PAD_MAX : paddle_q + STEP;
      end else if (bus.key_left && !bus.key_right) begin
        paddle_d = (paddle_q <= STEP) ? '0 : paddle_q - STEP;
      end

      unique case (state_q)
        S_IDLE: begin
          ball_x_d = paddle_d + BALL_OFS;
          ball_y_d = REST_Y;
          vx_d     = 1'b1;
          vy_d     = 1'b0;
          if (launch_now_c) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end
`ifdef AUTO_SERVE_EN
          else if (cnt_q == AUTO_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end

        S_PLAY: begin
          if (vx_q) begin
            if (ball_x_q + SPD >= BX_MAX) begin
              ball_x_d = BX_MAX;
              vx_d     = 1'b0;
            end else begin
              ball_x_d = ball_x_q + SPD;
            end
          end else begin
            if (ball_x_q <= SPD) begin
              ball_x_d = '0;
              vx_d     = 1'b1;
            end else begin
              ball_x_d = ball_x_q - SPD;
            end
          end

          if (!vy_q) begin
            if (ball_y_q <= SPD) begin
              ball_y_d = '0;
              vy_d     = 1'b1;
            end else begin
              ball_y_d = ball_y_q - SPD;
            end
          end else if (pad_hit_c) begin
            ball_y_d = REST_Y;
            vy_d     = 1'b0;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else if (ball_y_q + SZ + SPD >= SH) begin
            state_d  = S_MISS;
            ball_y_d = BY_MAX;
            miss_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            ball_y_d = ball_y_q + SPD;
          end
        end

        S_MISS: begin
          if (cnt_q == MISS_LAST) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ball_x_d = paddle_d + BALL_OFS;
            ball_y_d = REST_Y;
            vx_d     = 1'b1;
            vy_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    live_d = (state_d == S_PLAY);
  end

  assign bus.paddle_x  = paddle_q;
  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.ball_live = live_q;
  assign bus.miss      = miss_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Directed bench for pong_motion_ctrl: a default-size instance plus a tiny playfield instance for score saturation.
module tb_pong_motion_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef AUTO_SERVE_EN
  localparam logic AUTO_EXP = 1'b1;
`else
  localparam logic AUTO_EXP = 1'b0;
`endif

  pong_motion_ctrl_if m_if ();
  pong_motion_ctrl_if s_if ();

  pong_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  // Paddle spans the whole field, so every descent is a hit: one hit per 48 ticks.
  pong_motion_ctrl #(
    .SCR_W (48),
    .SCR_H (64),
    .PAD_W (48),
    .PAD_Y (40)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    m_if.frame_tick = 1'b1;
    s_if.frame_tick = 1'b1;
    @(negedge clk);
    m_if.frame_tick = 1'b0;
    s_if.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_if.paddle_x !== 10'd144) begin errors++; $display("FAIL reset_paddle_x: got %0d want 144", m_if.paddle_x); end
    checks++; if (m_if.ball_x !== 10'd152) begin errors++; $display("FAIL reset_ball_x: got %0d want 152", m_if.ball_x); end
    checks++; if (m_if.ball_y !== 10'd174) begin errors++; $display("FAIL reset_ball_y: got %0d want 174", m_if.ball_y); end
    checks++; if (m_if.score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", m_if.score); end
    checks++; if (m_if.ball_live !== 1'b0 || m_if.miss !== 1'b0) begin errors++; $display("FAIL reset_flags: live %b miss %b want 0 0", m_if.ball_live, m_if.miss); end
  endtask

  task automatic test_paddle();
    m_if.key_right = 1'b1;
    tick();
    checks++; if (m_if.paddle_x !== 10'd152) begin errors++; $display("FAIL right_step1: got %0d want 152", m_if.paddle_x); end
    tick();
    checks++; if (m_if.paddle_x !== 10'd160) begin errors++; $display("FAIL right_step2: got %0d want 160", m_if.paddle_x); end
    ticks(18);
    checks++; if (m_if.paddle_x !== 10'd288) begin errors++; $display("FAIL right_clamp: got %0d want 288", m_if.paddle_x); end
    checks++; if (m_if.ball_x !== 10'd296 || m_if.ball_y !== 10'd174) begin errors++; $display("FAIL right_ball_track: got %0d,%0d want 296,174", m_if.ball_x, m_if.ball_y); end
    m_if.key_right = 1'b0;
    m_if.key_left  = 1'b1;
    tick();
    checks++; if (m_if.paddle_x !== 10'd280) begin errors++; $display("FAIL left_step1: got %0d want 280", m_if.paddle_x); end
    ticks(39);
    checks++; if (m_if.paddle_x !== 10'd0) begin errors++; $display("FAIL left_clamp: got %0d want 0", m_if.paddle_x); end
    checks++; if (m_if.ball_x !== 10'd8) begin errors++; $display("FAIL left_ball_track: got %0d want 8", m_if.ball_x); end
    m_if.key_left = 1'b0;
    pulse_rst();
    m_if.key_left  = 1'b1;
    m_if.key_right = 1'b1;
    ticks(3);
    checks++; if (m_if.paddle_x !== 10'd144) begin errors++; $display("FAIL both_keys_hold: got %0d want 144", m_if.paddle_x); end
    m_if.key_left  = 1'b0;
    m_if.key_right = 1'b0;
  endtask

  task automatic test_serve();
    @(negedge clk);
    m_if.launch = 1'b1;
    @(negedge clk);
    m_if.launch = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_if.ball_live !== 1'b0) begin errors++; $display("FAIL serve_before_tick: live %b want 0", m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_live !== 1'b1 || m_if.ball_x !== 10'd152 || m_if.ball_y !== 10'd174) begin errors++; $display("FAIL serve_tick1: live %b pos %0d,%0d want 1 152,174", m_if.ball_live, m_if.ball_x, m_if.ball_y); end
    tick();
    checks++; if (m_if.ball_x !== 10'd153 || m_if.ball_y !== 10'd173) begin errors++; $display("FAIL serve_tick2: pos %0d,%0d want 153,173", m_if.ball_x, m_if.ball_y); end
  endtask

  task automatic test_bounce();
    ticks(150);
    checks++; if (m_if.ball_x !== 10'd303 || m_if.ball_y !== 10'd23) begin errors++; $display("FAIL pre_wall: pos %0d,%0d want 303,23", m_if.ball_x, m_if.ball_y); end
    tick();
    checks++; if (m_if.ball_x !== 10'd304 || m_if.ball_y !== 10'd22) begin errors++; $display("FAIL right_wall: pos %0d,%0d want 304,22", m_if.ball_x, m_if.ball_y); end
    tick();
    checks++; if (m_if.ball_x !== 10'd303 || m_if.ball_y !== 10'd21) begin errors++; $display("FAIL vx_reversed: pos %0d,%0d want 303,21", m_if.ball_x, m_if.ball_y); end
    ticks(21);
    checks++; if (m_if.ball_x !== 10'd282 || m_if.ball_y !== 10'd0) begin errors++; $display("FAIL top_wall: pos %0d,%0d want 282,0", m_if.ball_x, m_if.ball_y); end
    tick();
    checks++; if (m_if.ball_x !== 10'd281 || m_if.ball_y !== 10'd1) begin errors++; $display("FAIL vy_reversed: pos %0d,%0d want 281,1", m_if.ball_x, m_if.ball_y); end
  endtask

  task automatic test_paddle_hit();
    m_if.key_left = 1'b1;
    ticks(3);
    m_if.key_left = 1'b0;
    checks++; if (m_if.paddle_x !== 10'd120) begin errors++; $display("FAIL hit_paddle_place: got %0d want 120", m_if.paddle_x); end
    ticks(169);
    checks++; if (m_if.ball_x !== 10'd109 || m_if.ball_y !== 10'd173 || m_if.score !== 8'd0) begin errors++; $display("FAIL pre_hit: pos %0d,%0d score %0d want 109,173 0", m_if.ball_x, m_if.ball_y, m_if.score); end
    tick();
    checks++; if (m_if.ball_x !== 10'd108 || m_if.ball_y !== 10'd174 || m_if.score !== 8'd1 || m_if.ball_live !== 1'b1) begin errors++; $display("FAIL hit: pos %0d,%0d score %0d live %b want 108,174 1 1", m_if.ball_x, m_if.ball_y, m_if.score, m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_x !== 10'd107 || m_if.ball_y !== 10'd173) begin errors++; $display("FAIL after_hit_up: pos %0d,%0d want 107,173", m_if.ball_x, m_if.ball_y); end
  endtask

  task automatic test_miss();
    int miss_seen;
    m_if.key_left = 1'b1;
    ticks(2);
    m_if.key_left = 1'b0;
    ticks(394);
    checks++; if (m_if.ball_x !== 10'd289 || m_if.ball_y !== 10'd223 || m_if.miss !== 1'b0 || m_if.ball_live !== 1'b1) begin errors++; $display("FAIL pre_miss: pos %0d,%0d miss %b live %b want 289,223 0 1", m_if.ball_x, m_if.ball_y, m_if.miss, m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_x !== 10'd290 || m_if.ball_y !== 10'd224 || m_if.miss !== 1'b1 || m_if.ball_live !== 1'b0) begin errors++; $display("FAIL miss_entry: pos %0d,%0d miss %b live %b want 290,224 1 0", m_if.ball_x, m_if.ball_y, m_if.miss, m_if.ball_live); end
    @(negedge clk);
    checks++; if (m_if.miss !== 1'b0) begin errors++; $display("FAIL miss_one_cycle: miss %b want 0", m_if.miss); end
    miss_seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (m_if.miss === 1'b1) miss_seen++; end
    @(negedge clk);
    m_if.launch = 1'b1;
    @(negedge clk);
    m_if.launch = 1'b0;
    for (int i = 0; i < 19; i++) begin tick(); if (m_if.miss === 1'b1) miss_seen++; end
    checks++; if (miss_seen !== 0) begin errors++; $display("FAIL miss_repulse: pulses %0d want 0", miss_seen); end
    checks++; if (m_if.ball_x !== 10'd290 || m_if.ball_y !== 10'd224 || m_if.ball_live !== 1'b0) begin errors++; $display("FAIL miss_frozen: pos %0d,%0d live %b want 290,224 0", m_if.ball_x, m_if.ball_y, m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_x !== 10'd112 || m_if.ball_y !== 10'd174 || m_if.paddle_x !== 10'd104) begin errors++; $display("FAIL miss_return: pos %0d,%0d paddle %0d want 112,174 104", m_if.ball_x, m_if.ball_y, m_if.paddle_x); end
    checks++; if (m_if.score !== 8'd1 || m_if.ball_live !== 1'b0) begin errors++; $display("FAIL miss_score_kept: score %0d live %b want 1 0", m_if.score, m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_live !== 1'b0) begin errors++; $display("FAIL launch_in_miss_ignored: live %b want 0", m_if.ball_live); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m_if.launch     = 1'b1;
    m_if.frame_tick = 1'b1;
    @(negedge clk);
    m_if.launch     = 1'b0;
    m_if.frame_tick = 1'b0;
    checks++; if (m_if.ball_live !== 1'b1 || m_if.ball_x !== 10'd112) begin errors++; $display("FAIL launch_with_tick: live %b x %0d want 1 112", m_if.ball_live, m_if.ball_x); end
    tick();
    @(negedge clk);
    rst             = 1'b1;
    m_if.frame_tick = 1'b1;
    m_if.key_right  = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    m_if.frame_tick = 1'b0;
    m_if.key_right  = 1'b0;
    checks++; if (m_if.paddle_x !== 10'd144 || m_if.ball_x !== 10'd152 || m_if.ball_y !== 10'd174) begin errors++; $display("FAIL rst_mid_play: paddle %0d pos %0d,%0d want 144 152,174", m_if.paddle_x, m_if.ball_x, m_if.ball_y); end
    checks++; if (m_if.score !== 8'd0 || m_if.ball_live !== 1'b0) begin errors++; $display("FAIL rst_mid_play_flags: score %0d live %b want 0 0", m_if.score, m_if.ball_live); end
  endtask

  task automatic test_auto_serve();
    pulse_rst();
    ticks(59);
    checks++; if (m_if.ball_live !== 1'b0) begin errors++; $display("FAIL auto_tick59: live %b want 0", m_if.ball_live); end
    tick();
    checks++; if (m_if.ball_live !== AUTO_EXP) begin errors++; $display("FAIL auto_tick60: live %b want %b", m_if.ball_live, AUTO_EXP); end
  endtask

  task automatic test_score_saturate();
    pulse_rst();
    @(negedge clk);
    s_if.launch = 1'b1;
    @(negedge clk);
    s_if.launch = 1'b0;
    ticks(48);
    checks++; if (s_if.score !== 8'd0 || s_if.ball_y !== 10'd23) begin errors++; $display("FAIL sat_pre_first_hit: score %0d y %0d want 0 23", s_if.score, s_if.ball_y); end
    tick();
    checks++; if (s_if.score !== 8'd1 || s_if.ball_y !== 10'd24) begin errors++; $display("FAIL sat_first_hit: score %0d y %0d want 1 24", s_if.score, s_if.ball_y); end
    ticks(260 * 48);
    checks++; if (s_if.score !== 8'd255 || s_if.ball_live !== 1'b1) begin errors++; $display("FAIL sat_hold: score %0d live %b want 255 1", s_if.score, s_if.ball_live); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    m_if.frame_tick = 1'b0;
    m_if.key_left   = 1'b0;
    m_if.key_right  = 1'b0;
    m_if.launch     = 1'b0;
    s_if.frame_tick = 1'b0;
    s_if.key_left   = 1'b0;
    s_if.key_right  = 1'b0;
    s_if.launch     = 1'b0;

    test_reset();
    test_paddle();
    test_serve();
    test_bounce();
    test_paddle_hit();
    test_miss();
    test_back_to_back();
    test_auto_serve();
    test_score_saturate();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
